data_path: RTL and testbench
============================

// Module: data_path
// PURPOSE
//  32-bit single-bus processor datapath (Mini-SRC style). All register transfers go over one
//  shared 32-bit bus (BusMuxOut), driven by one-hot *out controls and captured by *in enables.
//  The control unit (or a testbench FSM) sequences T-states. The datapath holds R0-R15, PC, IR,
//  MAR, MDR, HI, LO, Y, Z (64-bit), in/out ports and an ALU. It exposes debug taps.
// PARAMETERS
//  DATA_WIDTH  32  bus/register width; the design is only required to work at 32
// PORTS
//  clock          in   1   rising-edge clock for every register
//  clear          in   1   asynchronous active-low reset; all registers -> 0
//  R0in..R15in    in   1   each: load GPR n from bus
//  IRin,PCin,MARin,MDRin,HIin,LOin  in 1  each: load named register
//  RYin,RZin      in   1   load Y from bus / load Z from ALU result
//  Outport_in     in   1   load output port from bus
//  Inport_in      in   1   load input-port register from Inport_data_in
//  IncPC          in   1   ALU forced to BusMuxOut+1 (overrides opcode)
//  R0out..R15out,HIout,LOout,Zhi_out,Zlo_out,PCout,MDRout,Inport_out,Cout  in 1  bus-source selects
//  Mem_read       in   1   MDR source select: 1 = MDR_Mem_lines, 0 = bus
//  opcode         in   5   ALU operation
//  MDR_Mem_lines  in   32  memory read data
//  Inport_data_in in   32  external input-port data
//  MAR_to_chip    out  32  MAR contents (memory address)
//  Outport_data_out out 32 output-port register
//  reg1..reg7     out  32  debug: R1..R7
//  regMDR,PC_VALUE,HI_VALUE,LO_VALUE,IR_VALUE  out 32  debug: MDR,PC,HI,LO,IR
//  BusMuxOut_out  out  32  debug: current bus value
// BEHAVIOUR
//  - Reset (clear=0, async): every register, including Z[63:0] and both ports, = 0.
//  - Bus: combinational mux. No select -> 0. Multiple selects -> fixed priority:
//    Cout > Inport > MDR > PC > Zlo > Zhi > LO > HI > R15 .. R0.
//  - C operand: sign-extended IR[18:0].
//  - Every register loads on a rising clock edge when its enable = 1, else holds. One-cycle latency.
//  - MDR loads (Mem_read ? MDR_Mem_lines : BusMuxOut) when MDRin=1.
//  - ALU inputs: A = Y, B = BusMuxOut. The result is 64-bit and is latched into Z when RZin=1.
//    For 32-bit ops, Z = {32'b0, r}.
//  - opcode: 00001 AND; 00010 OR; 00011 ADD; 00100 SUB (A-B); 00101 SHR; 00110 SHRA; 00111 SHL;
//    01000 ROR; 01001 ROL; 01010 MUL (signed, Z = full 64-bit product);
//    01011 DIV (signed, Zlo = quotient, Zhi = remainder); 01100 NEG (-B); 01101 NOT (~B);
//    others -> r = B.
//  - Shift/rotate amount: B[4:0]. An amount of 0 returns A unchanged.
//  - ADD/SUB wrap modulo 2^32; no flags.
//  - DIV by 0: quotient = 32'hFFFFFFFF, remainder = A.
//  - IncPC=1 -> Z = {32'b0, B+1}, regardless of opcode.
//  - Same register as bus source and destination in one cycle: it captures the pre-edge value.
// STRUCTURE
//  - Shared package: opcode constants (OP_AND..OP_NOT) and DATA_WIDTH.
//  - One sub-module: datapath_alu (A, B, opcode, IncPC -> 64-bit result), purely combinational.
//  - Registers and the bus mux are written inline.
// TESTING
//  1. Load: MDR<-0x10 (Mem_read, MDRin); MDRout+R2in+PCin -> R2 = PC = 0x10.
//     Likewise R3 = 0x14, R1 = 0x18.
//  2. Fetch: PCout+IncPC+MARin+RZin, then Zlo_out+PCin, Mem_read+MDRin with data 0x28918000,
//     then MDRout+IRin -> MAR = 0x10, PC = 0x11, IR = 0x28918000.
//  3. ROR: R2out+RYin, then R3out+opcode 01000+RZin, then Zlo_out+R1in -> R1 = 0x00010000.
//  4. ROL: same sequence with opcode 01001 -> R1 = 0x01000000, PC = 0x12.
//  5. MUL Y=0xFFFFFFFE x B=3 -> HI = 0xFFFFFFFF, LO = 0xFFFFFFFA.
//     DIV 7/2 -> Zlo = 3, Zhi = 1.
//     DIV by 0 -> Zlo = 0xFFFFFFFF, Zhi = 7.
//  6. Assert clear mid-sequence -> all debug outputs 0 immediately, without waiting for a clock.
//     No bus select -> BusMuxOut_out = 0.

Source files
------------

// File: rtl/data_path_pkg.sv
// Shared definitions for the single-bus datapath: word width, ALU opcodes,
// and the C-operand sign-extension helper used by the bus mux.
package data_path_pkg;

  localparam int DATA_WIDTH    = 32;
  localparam int C_FIELD_WIDTH = 19;
  localparam int SHAMT_WIDTH   = 5;

  localparam logic [DATA_WIDTH-1:0] WORD_ONE = 1;
  localparam logic [DATA_WIDTH-1:0] WORD_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [4:0] {
    OP_AND  = 5'b00001,
    OP_OR   = 5'b00010,
    OP_ADD  = 5'b00011,
    OP_SUB  = 5'b00100,
    OP_SHR  = 5'b00101,
    OP_SHRA = 5'b00110,
    OP_SHL  = 5'b00111,
    OP_ROR  = 5'b01000,
    OP_ROL  = 5'b01001,
    OP_MUL  = 5'b01010,
    OP_DIV  = 5'b01011,
    OP_NEG  = 5'b01100,
    OP_NOT  = 5'b01101
  } alu_op_e;

  // The C constant is the low 19 bits of IR, sign-extended to a full word.
  function automatic logic [DATA_WIDTH-1:0] sign_extend_c(input logic [C_FIELD_WIDTH-1:0] c_field);
    return {{(DATA_WIDTH-C_FIELD_WIDTH){c_field[C_FIELD_WIDTH-1]}}, c_field};
  endfunction

endpackage

// File: rtl/data_path_alu.sv
// Combinational ALU for the datapath. A comes from Y, B from the bus.
// Produces a double-width result so MUL and DIV can fill both halves of Z.
module datapath_alu
  import data_path_pkg::*;
(
  input  logic [DATA_WIDTH-1:0]   a_operand,
  input  logic [DATA_WIDTH-1:0]   b_operand,
  input  logic [4:0]              opcode,
  input  logic                    inc_pc,
  output logic [2*DATA_WIDTH-1:0] result
);

  logic signed [DATA_WIDTH-1:0]   a_signed;
  logic signed [DATA_WIDTH-1:0]   b_signed;
  logic signed [2*DATA_WIDTH-1:0] product;
  logic [SHAMT_WIDTH-1:0]         amount;

  assign a_signed = a_operand;
  assign b_signed = b_operand;
  assign amount   = b_operand[SHAMT_WIDTH-1:0];
  assign product  = $signed({{DATA_WIDTH{a_operand[DATA_WIDTH-1]}}, a_operand})
                  * $signed({{DATA_WIDTH{b_operand[DATA_WIDTH-1]}}, b_operand});

  logic signed [DATA_WIDTH-1:0] quotient;
  logic signed [DATA_WIDTH-1:0] remainder;
  logic signed [DATA_WIDTH-1:0] arith_shift;
  logic [SHAMT_WIDTH:0]         back_amount;

  // Operation select; IncPC wins over the opcode so the PC increment path never depends on it.
  always_comb begin
    result      = {{DATA_WIDTH{1'b0}}, b_operand};
    quotient    = '0;
    remainder   = '0;
    arith_shift = a_signed >>> amount;
    back_amount = (SHAMT_WIDTH+1)'(DATA_WIDTH) - {1'b0, amount};
    if (inc_pc) begin
      result = {{DATA_WIDTH{1'b0}}, b_operand + WORD_ONE};
    end else begin
      case (opcode)
        OP_AND:  result = {{DATA_WIDTH{1'b0}}, a_operand & b_operand};
        OP_OR:   result = {{DATA_WIDTH{1'b0}}, a_operand | b_operand};
        OP_ADD:  result = {{DATA_WIDTH{1'b0}}, a_operand + b_operand};
        OP_SUB:  result = {{DATA_WIDTH{1'b0}}, a_operand - b_operand};
        OP_SHR:  result = {{DATA_WIDTH{1'b0}}, a_operand >> amount};
        OP_SHRA: result = {{DATA_WIDTH{1'b0}}, arith_shift};
        OP_SHL:  result = {{DATA_WIDTH{1'b0}}, a_operand << amount};
        OP_ROR: begin
          if (amount == '0)
            result = {{DATA_WIDTH{1'b0}}, a_operand};
          else
            result = {{DATA_WIDTH{1'b0}}, (a_operand >> amount) | (a_operand << back_amount)};
        end
        OP_ROL: begin
          if (amount == '0)
            result = {{DATA_WIDTH{1'b0}}, a_operand};
          else
            result = {{DATA_WIDTH{1'b0}}, (a_operand << amount) | (a_operand >> back_amount)};
        end
        OP_MUL:  result = product;
        OP_DIV: begin
          // Divide-by-zero and the single overflowing case are resolved explicitly.
          if (b_operand == '0) begin
            result = {a_operand, {DATA_WIDTH{1'b1}}};
          end else if (a_operand == WORD_MIN && b_operand == {DATA_WIDTH{1'b1}}) begin
            result = {{DATA_WIDTH{1'b0}}, WORD_MIN};
          end else begin
            quotient  = a_signed / b_signed;
            remainder = a_signed % b_signed;
            result    = {remainder, quotient};
          end
        end
        OP_NEG:  result = {{DATA_WIDTH{1'b0}}, -b_operand};
        OP_NOT:  result = {{DATA_WIDTH{1'b0}}, ~b_operand};
        default: result = {{DATA_WIDTH{1'b0}}, b_operand};
      endcase
    end
  end

endmodule

// File: rtl/data_path.sv
// Single-bus processor datapath: sixteen GPRs, PC/IR/MAR/MDR, HI/LO, Y, 64-bit Z,
// I/O port registers and the ALU, all exchanging data over one shared bus.
module data_path
  import data_path_pkg::*;
(
  input  logic                  clock,
  input  logic                  clear,
  input  logic                  R0in,  R1in,  R2in,  R3in,  R4in,  R5in,  R6in,  R7in,
  input  logic                  R8in,  R9in,  R10in, R11in, R12in, R13in, R14in, R15in,
  input  logic                  IRin,
  input  logic                  PCin,
  input  logic                  MARin,
  input  logic                  MDRin,
  input  logic                  HIin,
  input  logic                  LOin,
  input  logic                  RYin,
  input  logic                  RZin,
  input  logic                  Outport_in,
  input  logic                  Inport_in,
  input  logic                  IncPC,
  input  logic                  R0out, R1out, R2out, R3out, R4out, R5out, R6out, R7out,
  input  logic                  R8out, R9out, R10out, R11out, R12out, R13out, R14out, R15out,
  input  logic                  HIout,
  input  logic                  LOout,
  input  logic                  Zhi_out,
  input  logic                  Zlo_out,
  input  logic                  PCout,
  input  logic                  MDRout,
  input  logic                  Inport_out,
  input  logic                  Cout,
  input  logic                  Mem_read,
  input  logic [4:0]            opcode,
  input  logic [DATA_WIDTH-1:0] MDR_Mem_lines,
  input  logic [DATA_WIDTH-1:0] Inport_data_in,
  output logic [DATA_WIDTH-1:0] MAR_to_chip,
  output logic [DATA_WIDTH-1:0] Outport_data_out,
  output logic [DATA_WIDTH-1:0] reg1,
  output logic [DATA_WIDTH-1:0] reg2,
  output logic [DATA_WIDTH-1:0] reg3,
  output logic [DATA_WIDTH-1:0] reg4,
  output logic [DATA_WIDTH-1:0] reg5,
  output logic [DATA_WIDTH-1:0] reg6,
  output logic [DATA_WIDTH-1:0] reg7,
  output logic [DATA_WIDTH-1:0] regMDR,
  output logic [DATA_WIDTH-1:0] PC_VALUE,
  output logic [DATA_WIDTH-1:0] HI_VALUE,
  output logic [DATA_WIDTH-1:0] LO_VALUE,
  output logic [DATA_WIDTH-1:0] IR_VALUE,
  output logic [DATA_WIDTH-1:0] BusMuxOut_out
);

  logic [15:0]                gpr_load;
  logic [15:0]                gpr_drive;
  logic [DATA_WIDTH-1:0]      gpr [16];
  logic [DATA_WIDTH-1:0]      pc_reg, ir_reg, mar_reg, mdr_reg;
  logic [DATA_WIDTH-1:0]      hi_reg, lo_reg, y_reg;
  logic [DATA_WIDTH-1:0]      inport_reg, outport_reg;
  logic [2*DATA_WIDTH-1:0]    z_reg;
  logic [DATA_WIDTH-1:0]      bus;
  logic [DATA_WIDTH-1:0]      c_operand;
  logic [2*DATA_WIDTH-1:0]    alu_result;

  assign gpr_load  = {R15in, R14in, R13in, R12in, R11in, R10in, R9in, R8in,
                      R7in,  R6in,  R5in,  R4in,  R3in,  R2in,  R1in, R0in};
  assign gpr_drive = {R15out, R14out, R13out, R12out, R11out, R10out, R9out, R8out,
                      R7out,  R6out,  R5out,  R4out,  R3out,  R2out,  R1out, R0out};
  assign c_operand = sign_extend_c(ir_reg[C_FIELD_WIDTH-1:0]);

  // Bus mux: sources are applied lowest priority first, so a later match overrides an earlier one.
  always_comb begin
    bus = '0;
    for (int i = 0; i < 16; i++) begin
      if (gpr_drive[i]) bus = gpr[i];
    end
    if (HIout)      bus = hi_reg;
    if (LOout)      bus = lo_reg;
    if (Zhi_out)    bus = z_reg[2*DATA_WIDTH-1:DATA_WIDTH];
    if (Zlo_out)    bus = z_reg[DATA_WIDTH-1:0];
    if (PCout)      bus = pc_reg;
    if (MDRout)     bus = mdr_reg;
    if (Inport_out) bus = inport_reg;
    if (Cout)       bus = c_operand;
  end

  datapath_alu u_alu (
    .a_operand (y_reg),
    .b_operand (bus),
    .opcode    (opcode),
    .inc_pc    (IncPC),
    .result    (alu_result)
  );

  // General-purpose register file; each register captures the bus when its enable is set.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      for (int i = 0; i < 16; i++) gpr[i] <= '0;
    end else begin
      for (int i = 0; i < 16; i++) begin
        if (gpr_load[i]) gpr[i] <= bus;
      end
    end
  end

  // Program-flow and memory-interface registers; MDR can take memory data instead of the bus.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      pc_reg  <= '0;
      ir_reg  <= '0;
      mar_reg <= '0;
      mdr_reg <= '0;
    end else begin
      if (PCin)  pc_reg  <= bus;
      if (IRin)  ir_reg  <= bus;
      if (MARin) mar_reg <= bus;
      if (MDRin) mdr_reg <= Mem_read ? MDR_Mem_lines : bus;
    end
  end

  // Arithmetic holding registers: Y feeds ALU operand A, Z captures the double-width ALU result.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      hi_reg <= '0;
      lo_reg <= '0;
      y_reg  <= '0;
      z_reg  <= '0;
    end else begin
      if (HIin) hi_reg <= bus;
      if (LOin) lo_reg <= bus;
      if (RYin) y_reg  <= bus;
      if (RZin) z_reg  <= alu_result;
    end
  end

  // I/O port registers: the input port samples the external pins, the output port samples the bus.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      inport_reg  <= '0;
      outport_reg <= '0;
    end else begin
      if (Inport_in)  inport_reg  <= Inport_data_in;
      if (Outport_in) outport_reg <= bus;
    end
  end

  assign MAR_to_chip      = mar_reg;
  assign Outport_data_out = outport_reg;
  assign reg1             = gpr[1];
  assign reg2             = gpr[2];
  assign reg3             = gpr[3];
  assign reg4             = gpr[4];
  assign reg5             = gpr[5];
  assign reg6             = gpr[6];
  assign reg7             = gpr[7];
  assign regMDR           = mdr_reg;
  assign PC_VALUE         = pc_reg;
  assign HI_VALUE         = hi_reg;
  assign LO_VALUE         = lo_reg;
  assign IR_VALUE         = ir_reg;
  assign BusMuxOut_out    = bus;

endmodule

// File: tb/tb_data_path.sv
// Self-checking bench for data_path: directed transfer sequences plus randomized
// ALU operations and bus-priority scenarios, all checked against a behavioural model.
module tb_data_path;

  logic        clock = 1'b0;
  logic        clear;
  logic [15:0] r_in, r_out;
  logic        IRin, PCin, MARin, MDRin, HIin, LOin, RYin, RZin, Outport_in, Inport_in, IncPC;
  logic        HIout, LOout, Zhi_out, Zlo_out, PCout, MDRout, Inport_out, Cout, Mem_read;
  logic [4:0]  opcode;
  logic [31:0] MDR_Mem_lines, Inport_data_in;
  logic [31:0] MAR_to_chip, Outport_data_out, regMDR, PC_VALUE, HI_VALUE, LO_VALUE, IR_VALUE;
  logic [31:0] BusMuxOut_out;
  logic [31:0] reg_dbg [1:7];

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  logic [31:0] m_gpr [16];
  logic [31:0] m_pc, m_ir, m_mar, m_mdr, m_hi, m_lo, m_y, m_in, m_out;
  logic [63:0] m_z;

  always #5 clock = ~clock;

  data_path dut (
    .clock(clock), .clear(clear),
    .R0in(r_in[0]),   .R1in(r_in[1]),   .R2in(r_in[2]),   .R3in(r_in[3]),
    .R4in(r_in[4]),   .R5in(r_in[5]),   .R6in(r_in[6]),   .R7in(r_in[7]),
    .R8in(r_in[8]),   .R9in(r_in[9]),   .R10in(r_in[10]), .R11in(r_in[11]),
    .R12in(r_in[12]), .R13in(r_in[13]), .R14in(r_in[14]), .R15in(r_in[15]),
    .IRin(IRin), .PCin(PCin), .MARin(MARin), .MDRin(MDRin), .HIin(HIin), .LOin(LOin),
    .RYin(RYin), .RZin(RZin), .Outport_in(Outport_in), .Inport_in(Inport_in), .IncPC(IncPC),
    .R0out(r_out[0]),   .R1out(r_out[1]),   .R2out(r_out[2]),   .R3out(r_out[3]),
    .R4out(r_out[4]),   .R5out(r_out[5]),   .R6out(r_out[6]),   .R7out(r_out[7]),
    .R8out(r_out[8]),   .R9out(r_out[9]),   .R10out(r_out[10]), .R11out(r_out[11]),
    .R12out(r_out[12]), .R13out(r_out[13]), .R14out(r_out[14]), .R15out(r_out[15]),
    .HIout(HIout), .LOout(LOout), .Zhi_out(Zhi_out), .Zlo_out(Zlo_out), .PCout(PCout),
    .MDRout(MDRout), .Inport_out(Inport_out), .Cout(Cout), .Mem_read(Mem_read),
    .opcode(opcode), .MDR_Mem_lines(MDR_Mem_lines), .Inport_data_in(Inport_data_in),
    .MAR_to_chip(MAR_to_chip), .Outport_data_out(Outport_data_out),
    .reg1(reg_dbg[1]), .reg2(reg_dbg[2]), .reg3(reg_dbg[3]), .reg4(reg_dbg[4]),
    .reg5(reg_dbg[5]), .reg6(reg_dbg[6]), .reg7(reg_dbg[7]),
    .regMDR(regMDR), .PC_VALUE(PC_VALUE), .HI_VALUE(HI_VALUE), .LO_VALUE(LO_VALUE),
    .IR_VALUE(IR_VALUE), .BusMuxOut_out(BusMuxOut_out)
  );

  // Single comparison point: counts every check and reports any disagreement.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic clearControls();
    r_in = '0; r_out = '0;
    IRin = 0; PCin = 0; MARin = 0; MDRin = 0; HIin = 0; LOin = 0; RYin = 0; RZin = 0;
    Outport_in = 0; Inport_in = 0; IncPC = 0;
    HIout = 0; LOout = 0; Zhi_out = 0; Zlo_out = 0; PCout = 0; MDRout = 0; Inport_out = 0;
    Cout = 0; Mem_read = 0; opcode = '0;
  endtask

  task automatic modelReset();
    for (int i = 0; i < 16; i++) m_gpr[i] = '0;
    m_pc = '0; m_ir = '0; m_mar = '0; m_mdr = '0; m_hi = '0; m_lo = '0;
    m_y = '0; m_in = '0; m_out = '0; m_z = '0;
  endtask

  // Bus value from the selects: the highest-priority asserted source wins, else zero.
  function automatic logic [31:0] refBus();
    int c_val;
    c_val = {m_ir[18:0], 13'b0};
    c_val = c_val >>> 13;
    if (Cout)       return c_val;
    if (Inport_out) return m_in;
    if (MDRout)     return m_mdr;
    if (PCout)      return m_pc;
    if (Zlo_out)    return m_z[31:0];
    if (Zhi_out)    return m_z[63:32];
    if (LOout)      return m_lo;
    if (HIout)      return m_hi;
    for (int i = 15; i >= 0; i--) if (r_out[i]) return m_gpr[i];
    return '0;
  endfunction

  // ALU reference computed with wide integer arithmetic.
  function automatic logic [63:0] refAlu(input logic [4:0] op, input logic [31:0] a,
                                         input logic [31:0] b, input logic inc);
    int          ia, ib, amt;
    longint      sa, sb, q, rem;
    logic [63:0] dbl;
    logic [31:0] r32;
    ia = a; ib = b; sa = ia; sb = ib;
    amt = int'(b[4:0]);
    if (inc) begin
      r32 = b + 32'd1;
      return {32'h0, r32};
    end
    case (op)
      5'b00001: r32 = a & b;
      5'b00010: r32 = a | b;
      5'b00011: r32 = a + b;
      5'b00100: r32 = a - b;
      5'b00101: r32 = a >> amt;
      5'b00110: r32 = 32'(sa >>> amt);
      5'b00111: r32 = a << amt;
      5'b01000: begin dbl = {a, a} >> amt; r32 = dbl[31:0]; end
      5'b01001: begin dbl = {a, a} << amt; r32 = dbl[63:32]; end
      5'b01010: return 64'(sa * sb);
      5'b01011: begin
        if (b == 32'h0) return {a, 32'hFFFFFFFF};
        q   = sa / sb;
        rem = sa - q * sb;
        return {32'(rem), 32'(q)};
      end
      5'b01100: r32 = 32'h0 - b;
      5'b01101: r32 = ~b;
      default:  r32 = b;
    endcase
    return {32'h0, r32};
  endfunction

  // One register-transfer step: model and DUT both clock the current controls, then controls drop.
  task automatic applyStimulus();
    logic [31:0] bus_v;
    logic [63:0] alu_v;
    bus_v = refBus();
    alu_v = refAlu(opcode, m_y, bus_v, IncPC);
    @(posedge clock);
    for (int i = 0; i < 16; i++) if (r_in[i]) m_gpr[i] = bus_v;
    if (PCin)       m_pc  = bus_v;
    if (IRin)       m_ir  = bus_v;
    if (MARin)      m_mar = bus_v;
    if (MDRin)      m_mdr = Mem_read ? MDR_Mem_lines : bus_v;
    if (HIin)       m_hi  = bus_v;
    if (LOin)       m_lo  = bus_v;
    if (RYin)       m_y   = bus_v;
    if (RZin)       m_z   = alu_v;
    if (Outport_in) m_out = bus_v;
    if (Inport_in)  m_in  = Inport_data_in;
    #1;
    clearControls();
  endtask

  task automatic checkAll();
    for (int i = 1; i <= 7; i++) checkOutput($sformatf("reg%0d", i), reg_dbg[i], m_gpr[i]);
    checkOutput("mar", MAR_to_chip, m_mar);
    checkOutput("outport", Outport_data_out, m_out);
    checkOutput("mdr", regMDR, m_mdr);
    checkOutput("pc", PC_VALUE, m_pc);
    checkOutput("hi", HI_VALUE, m_hi);
    checkOutput("lo", LO_VALUE, m_lo);
    checkOutput("ir", IR_VALUE, m_ir);
  endtask

  task automatic checkZeros(input string tag);
    for (int i = 1; i <= 7; i++) checkOutput($sformatf("%s_reg%0d", tag, i), reg_dbg[i], 32'h0);
    checkOutput({tag, "_mar"}, MAR_to_chip, 32'h0);
    checkOutput({tag, "_outport"}, Outport_data_out, 32'h0);
    checkOutput({tag, "_mdr"}, regMDR, 32'h0);
    checkOutput({tag, "_pc"}, PC_VALUE, 32'h0);
    checkOutput({tag, "_hi"}, HI_VALUE, 32'h0);
    checkOutput({tag, "_lo"}, LO_VALUE, 32'h0);
    checkOutput({tag, "_ir"}, IR_VALUE, 32'h0);
    checkOutput({tag, "_bus"}, BusMuxOut_out, 32'h0);
  endtask

  task automatic memToReg(input logic [31:0] value, input int idx, input logic also_pc);
    MDR_Mem_lines = value; Mem_read = 1; MDRin = 1;
    applyStimulus();
    MDRout = 1; r_in[idx] = 1; PCin = also_pc;
    applyStimulus();
  endtask

  task automatic loadViaInport(input logic [31:0] value, input int idx);
    Inport_data_in = value; Inport_in = 1;
    applyStimulus();
    Inport_out = 1; r_in[idx] = 1;
    applyStimulus();
  endtask

  task automatic fetchIncrement();
    PCout = 1; IncPC = 1; MARin = 1; RZin = 1;
    applyStimulus();
    Zlo_out = 1; PCin = 1;
    applyStimulus();
  endtask

  // Y <- a, Z <- alu(a, b), then LO <- Zlo and HI <- Zhi.
  task automatic runAluOp(input logic [31:0] a, input logic [31:0] b, input logic [4:0] op,
                          input logic inc);
    Inport_data_in = a; Inport_in = 1;
    applyStimulus();
    Inport_out = 1; RYin = 1;
    applyStimulus();
    Inport_data_in = b; Inport_in = 1;
    applyStimulus();
    Inport_out = 1; opcode = op; IncPC = inc; RZin = 1;
    applyStimulus();
    Zlo_out = 1; LOin = 1;
    applyStimulus();
    Zhi_out = 1; HIin = 1;
    applyStimulus();
  endtask

  initial begin
    logic [31:0] a, b;
    logic [4:0]  op;
    clearControls();
    MDR_Mem_lines = '0; Inport_data_in = '0;
    modelReset();
    clear = 0;
    #12;
    checkZeros("reset");
    clear = 1;
    #1;

    // Register loads from memory
    memToReg(32'h10, 2, 1'b1);
    checkOutput("load_r2", reg_dbg[2], 32'h10);
    checkOutput("load_pc", PC_VALUE, 32'h10);
    memToReg(32'h14, 3, 1'b0);
    memToReg(32'h18, 1, 1'b0);
    checkOutput("load_r3", reg_dbg[3], 32'h14);
    checkOutput("load_r1", reg_dbg[1], 32'h18);

    // Instruction fetch
    fetchIncrement();
    MDR_Mem_lines = 32'h28918000; Mem_read = 1; MDRin = 1;
    applyStimulus();
    MDRout = 1; IRin = 1;
    applyStimulus();
    checkOutput("fetch_mar", MAR_to_chip, 32'h10);
    checkOutput("fetch_pc", PC_VALUE, 32'h11);
    checkOutput("fetch_ir", IR_VALUE, 32'h28918000);

    // ROR and ROL of R2 by R3
    r_out[2] = 1; RYin = 1;
    applyStimulus();
    r_out[3] = 1; opcode = 5'b01000; RZin = 1;
    applyStimulus();
    Zlo_out = 1; r_in[1] = 1;
    applyStimulus();
    checkOutput("ror_r1", reg_dbg[1], 32'h00010000);
    fetchIncrement();
    r_out[2] = 1; RYin = 1;
    applyStimulus();
    r_out[3] = 1; opcode = 5'b01001; RZin = 1;
    applyStimulus();
    Zlo_out = 1; r_in[1] = 1;
    applyStimulus();
    checkOutput("rol_r1", reg_dbg[1], 32'h01000000);
    checkOutput("rol_pc", PC_VALUE, 32'h12);

    // MUL and DIV corner cases
    runAluOp(32'hFFFFFFFE, 32'h3, 5'b01010, 1'b0);
    checkOutput("mul_hi", HI_VALUE, 32'hFFFFFFFF);
    checkOutput("mul_lo", LO_VALUE, 32'hFFFFFFFA);
    runAluOp(32'h7, 32'h2, 5'b01011, 1'b0);
    checkOutput("div_lo", LO_VALUE, 32'h3);
    checkOutput("div_hi", HI_VALUE, 32'h1);
    runAluOp(32'h7, 32'h0, 5'b01011, 1'b0);
    checkOutput("div0_lo", LO_VALUE, 32'hFFFFFFFF);
    checkOutput("div0_hi", HI_VALUE, 32'h7);
    checkAll();

    // Randomized ALU operations
    for (int n = 0; n < 40; n++) begin
      a  = $urandom;
      op = 5'($urandom_range(15, 0));
      case ($urandom_range(3, 0))
        0:       b = 32'h0;
        1:       b = $urandom_range(40, 0);
        default: b = $urandom;
      endcase
      runAluOp(a, b, op, ($urandom_range(7, 0) == 0));
      checkOutput($sformatf("alu_lo_op%0d", op), LO_VALUE, m_lo);
      checkOutput($sformatf("alu_hi_op%0d", op), HI_VALUE, m_hi);
    end

    // Randomized bus priority with simultaneous selects
    for (int i = 0; i < 16; i++) loadViaInport($urandom, i);
    Inport_data_in = $urandom; Inport_in = 1;
    applyStimulus();
    Inport_out = 1; IRin = 1; HIin = 1;
    applyStimulus();
    Inport_data_in = $urandom; Inport_in = 1; MDR_Mem_lines = $urandom; Mem_read = 1; MDRin = 1;
    applyStimulus();
    for (int n = 0; n < 30; n++) begin
      r_out      = 16'($urandom);
      r_in       = 16'($urandom) & 16'h00FE;
      HIout      = ($urandom_range(5, 0) == 0);
      LOout      = ($urandom_range(5, 0) == 0);
      Zhi_out    = ($urandom_range(5, 0) == 0);
      Zlo_out    = ($urandom_range(5, 0) == 0);
      PCout      = ($urandom_range(5, 0) == 0);
      MDRout     = ($urandom_range(5, 0) == 0);
      Inport_out = ($urandom_range(5, 0) == 0);
      Cout       = ($urandom_range(5, 0) == 0);
      Outport_in = 1;
      LOin       = ($urandom_range(3, 0) == 0);
      #1;
      checkOutput("bus_prio", BusMuxOut_out, refBus());
      applyStimulus();
      checkOutput("outport", Outport_data_out, m_out);
    end
    #1;
    checkOutput("bus_idle", BusMuxOut_out, 32'h0);
    checkAll();

    // Asynchronous clear in the middle of a transfer
    PCout = 1; IncPC = 1; RZin = 1; MARin = 1;
    #3;
    clear = 0;
    #1;
    modelReset();
    checkZeros("midclear");
    clearControls();
    #1;
    checkOutput("idle_after_clear", BusMuxOut_out, 32'h0);
    @(negedge clock);
    clear = 1;
    #1;
    fetchIncrement();
    checkOutput("post_clear_pc", PC_VALUE, 32'h1);
    checkAll();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
